// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver.
// The helper sizes the shared pulse/gap down-counter.
package sr_latch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic CMD_SET   = 1'b1;
   localparam logic CMD_RESET = 1'b0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command handshake into the SR latch driver: valid/ready plus direction bit.
// Master issues commands; slave (the driver) accepts only while idle.
interface sr_latch_driver_if;

   logic cmd_valid;
   logic cmd_set;
   logic cmd_ready;

   modport master (output cmd_valid, output cmd_set, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_set, output cmd_ready);

endinterface

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchronizer with a selectable reset value; 2-cycle latency.
// No handshake: the sampled value simply follows d.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns set/reset commands into fixed-width S/R pulses, guard gap, then readback check.
// done lands PULSE_CYCLES+GAP_CYCLES+1 cycles after accept; cmd_ready is high only in IDLE.
module sr_latch_driver
   import sr_latch_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   sr_latch_driver_if.slave    cmd,
   output logic                S,
   output logic                R,
   input  logic                Q,
   input  logic                Qbar,
   output logic                done,
   output logic                fault,
   output logic                state_q,
   output logic                invalid
);

   if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("PULSE_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be >= 1");
   end

   localparam int CW = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

   state_t          fsm_q, fsm_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            exp_q, exp_d;
   logic            s_q, s_d;
   logic            r_q, r_d;
   logic            invalid_q, invalid_d;
   logic            q_sync, qbar_sync;
   logic            accept;

   // Latch outputs are asynchronous; reset values encode a valid "cleared" latch.
   sync_2ff #(.RST_VAL(1'b0)) u_sync_q (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (Q),
      .q     (q_sync)
   );

   sync_2ff #(.RST_VAL(1'b1)) u_sync_qbar (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (Qbar),
      .q     (qbar_sync)
   );

   assign accept = cmd.cmd_valid && (fsm_q == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= IDLE;
         cnt_q     <= '0;
         exp_q     <= CMD_RESET;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         fsm_q     <= fsm_d;
         cnt_q     <= cnt_d;
         exp_q     <= exp_d;
         s_q       <= s_d;
         r_q       <= r_d;
         invalid_q <= invalid_d;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      exp_d = exp_q;
      case (fsm_q)
         IDLE: begin
            if (accept) begin
               fsm_d = PULSE;
               cnt_d = P_LOAD;
               exp_d = cmd.cmd_set;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               fsm_d = GAP;
               cnt_d = G_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               fsm_d = CHECK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         CHECK: begin
            fsm_d = IDLE;
            cnt_d = '0;
         end
         default: begin
            fsm_d = IDLE;
            cnt_d = '0;
         end
      endcase
      // Pulse drives are registered from the next state so S/R leave clean flops.
      s_d       = (fsm_d == PULSE) && (exp_d == CMD_SET);
      r_d       = (fsm_d == PULSE) && (exp_d == CMD_RESET);
      invalid_d = (q_sync == qbar_sync);
   end

   always_comb begin
      cmd.cmd_ready = (fsm_q == IDLE);
      S             = s_q;
      R             = r_q;
      done          = (fsm_q == CHECK);
      fault         = (fsm_q == CHECK) && ((q_sync != exp_q) || invalid_q);
      state_q       = q_sync;
      invalid       = invalid_q;
   end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural NOR latch cell.
// Per-cycle vector table for command sequences, hand sequences for fault/reset corners.
module tb_sr_latch_driver;

   logic clk = 1'b0;
   logic rst_n;
   logic S, R, done, fault, state_q, invalid;
   logic q_pin, qbar_pin;

   logic lq  = 1'b0;
   logic lqb = 1'b1;
   logic force_en = 1'b0;
   logic fq  = 1'b0;
   logic fqb = 1'b1;

   int total = 0;
   int bad   = 0;

   sr_latch_driver_if cmd_if ();

   sr_latch_driver #(
      .PULSE_CYCLES (4),
      .GAP_CYCLES   (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cmd     (cmd_if),
      .S       (S),
      .R       (R),
      .Q       (q_pin),
      .Qbar    (qbar_pin),
      .done    (done),
      .fault   (fault),
      .state_q (state_q),
      .invalid (invalid)
   );

   always #5 clk = ~clk;

   // Behavioural NOR latch: S sets, R resets, both high forces both outputs low.
   always @(S or R) begin
      if (S && !R) begin
         lq  = 1'b1;
         lqb = 1'b0;
      end else if (R && !S) begin
         lq  = 1'b0;
         lqb = 1'b1;
      end else if (S && R) begin
         lq  = 1'b0;
         lqb = 1'b0;
      end
   end

   assign q_pin    = force_en ? fq  : lq;
   assign qbar_pin = force_en ? fqb : lqb;

   always @(negedge clk) begin
      assert (!(S && R)) else $error("FAIL sr_excl: S=%0b R=%0b both high", S, R);
   end

   typedef struct {
      logic vld;
      logic set;
      logic e_rdy;
      logic e_s;
      logic e_r;
      logic e_done;
      logic e_fault;
      logic c_stq;
      logic e_stq;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_row(input logic vld, input logic set, input logic rdy,
                          input logic s, input logic r, input logic dn,
                          input logic flt, input logic c_stq, input logic e_stq);
      vec_t v;
      v.vld = vld; v.set = set; v.e_rdy = rdy; v.e_s = s; v.e_r = r;
      v.e_done = dn; v.e_fault = flt; v.c_stq = c_stq; v.e_stq = e_stq;
      vecs.push_back(v);
   endtask

   // One full command: accept row, 4 pulse rows, 2 gap rows, 1 check row.
   // With busy=1, valid stays high and cmd_set alternates while the driver is busy.
   task automatic add_cmd(input logic set, input logic busy, input logic flt, input logic stq);
      add_row(1'b1, set, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++)
         add_row(busy, set ^ i[0], 1'b0, set, !set, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 5; i <= 6; i++)
         add_row(busy, set ^ i[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add_row(busy, !set, 1'b0, 1'b0, 1'b0, 1'b1, flt, 1'b1, stq);
   endtask

   task automatic run_vectors(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         chk($sformatf("%s[%0d].ready", tag, i), cmd_if.cmd_ready, vecs[i].e_rdy);
         chk($sformatf("%s[%0d].S", tag, i), S, vecs[i].e_s);
         chk($sformatf("%s[%0d].R", tag, i), R, vecs[i].e_r);
         chk($sformatf("%s[%0d].done", tag, i), done, vecs[i].e_done);
         chk($sformatf("%s[%0d].fault", tag, i), fault, vecs[i].e_fault);
         chk($sformatf("%s[%0d].sr_excl", tag, i), S && R, 1'b0);
         if (vecs[i].c_stq)
            chk($sformatf("%s[%0d].state_q", tag, i), state_q, vecs[i].e_stq);
         cmd_if.cmd_valid = vecs[i].vld;
         cmd_if.cmd_set   = vecs[i].set;
      end
      vecs.delete();
   endtask

   initial begin
      rst_n            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_set   = 1'b0;

      // Reset held for 3 cycles
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst.S", S, 1'b0);
         chk("rst.R", R, 1'b0);
         chk("rst.ready", cmd_if.cmd_ready, 1'b1);
         chk("rst.done", done, 1'b0);
         chk("rst.fault", fault, 1'b0);
         chk("rst.invalid", invalid, 1'b0);
         chk("rst.state_q", state_q, 1'b0);
      end
      rst_n = 1'b1;

      // Set then reset, then back-to-back alternating commands with valid held high
      add_cmd(1'b1, 1'b0, 1'b0, 1'b1);
      add_cmd(1'b0, 1'b0, 1'b0, 1'b0);
      add_cmd(1'b1, 1'b1, 1'b0, 1'b1);
      add_cmd(1'b0, 1'b1, 1'b0, 1'b0);
      add_cmd(1'b1, 1'b1, 1'b0, 1'b1);
      add_cmd(1'b0, 1'b1, 1'b0, 1'b0);
      add_row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_vectors("basic");

      // Readback stuck at 0 during a set command
      force_en = 1'b1;
      fq       = 1'b0;
      fqb      = 1'b1;
      add_cmd(1'b1, 1'b0, 1'b1, 1'b0);
      add_row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      run_vectors("fault");

      fqb = 1'b0;
      repeat (3) @(negedge clk);
      chk("inv.both_low", invalid, 1'b1);
      chk("inv.no_done", done, 1'b0);

      force_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("inv.cleared", invalid, 1'b0);
      chk("inv.state_q", state_q, 1'b1);

      // Reset asserted in the 2nd cycle of S high
      @(negedge clk);
      chk("mid.ready0", cmd_if.cmd_ready, 1'b1);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_set   = 1'b1;
      @(negedge clk);
      chk("mid.S_first", S, 1'b1);
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid.S_second", S, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.S_async_drop", S, 1'b0);
      chk("mid.R_async", R, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("mid.rst_S", S, 1'b0);
         chk("mid.rst_done", done, 1'b0);
         chk("mid.rst_fault", fault, 1'b0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("post[%0d].ready", i), cmd_if.cmd_ready, 1'b1);
         chk($sformatf("post[%0d].done", i), done, 1'b0);
         chk($sformatf("post[%0d].fault", i), fault, 1'b0);
         chk($sformatf("post[%0d].S", i), S, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Clocked controller for the NOR SR latch cell. It accepts set/reset commands over a valid/ready handshake and turns each one into a clean, fixed-width S or R pulse. S and R are never asserted together. After each pulse it enforces a both-low guard gap, then reads back the latch's Q/Qbar through synchronizers and reports done/fault. It sits between synchronous control logic and the asynchronous latch.

Parameters:
PULSE_CYCLES, 4, clock cycles S or R is held high per command; must be >=1 (elaboration error otherwise).
GAP_CYCLES, 2, clock cycles with S=R=0 after a pulse, before the readback check; must be >=1.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command request.
cmd_set  input  1  1 = set latch (pulse S), 0 = reset latch (pulse R); sampled on accept.
cmd_ready  output  1  high only in IDLE.
S  output  1  registered set drive to latch.
R  output  1  registered reset drive to latch.
Q  input  1  latch output, asynchronous to clk.
Qbar  input  1  latch complement output, asynchronous to clk.
done  output  1  one-cycle pulse when a command completes.
fault  output  1  one-cycle pulse coincident with done when readback mismatches.
state_q  output  1  synchronized latch value (Q after 2 flops).
invalid  output  1  level, registered: synchronized Q == synchronized Qbar.

Behaviour:
- Reset (async, immediate): S=0, R=0, done=0, fault=0, FSM=IDLE (cmd_ready=1). Q sync flops reset to 0 and Qbar sync flops reset to 1, so state_q=0 and invalid=0.
- Accept: cmd_valid && cmd_ready at edge k. cmd_set is captured into exp_q. cmd_valid while busy is ignored and nothing is latched.
- FSM states and transitions:
  - IDLE -> PULSE on accept.
  - PULSE: exactly one of S/R is high for PULSE_CYCLES cycles (k+1 .. k+PULSE_CYCLES), then -> GAP.
  - GAP: S=R=0 for GAP_CYCLES cycles, then -> CHECK.
  - CHECK: one cycle. done=1; fault=1 if state_q != exp_q or invalid=1. Then -> IDLE.
- Latency: done is asserted in cycle k+PULSE_CYCLES+GAP_CYCLES+1. cmd_ready returns the following cycle, so there is no back-to-back accept in the CHECK cycle.
- Invariant: S && R == 0 in every cycle, including across reset.
- S/R are driven only from state and registered direction, never combinationally from inputs.
- Redundant command (set while already set): a full pulse is still issued and checked normally.
- Counter: a single down-counter of width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1), reloaded on each state entry. It holds 0 in IDLE and CHECK.
- Reset mid-operation: S/R drop asynchronously, the command is discarded, no done/fault is produced, and the FSM is in IDLE after rst_n release.
- invalid and state_q update every cycle regardless of FSM state.
- Q/Qbar are used only through the synchronizers, never directly.

Decomposition:
- Package sr_latch_pkg:
  - state enum typedef (IDLE, PULSE, GAP, CHECK).
  - constants CMD_SET=1'b1, CMD_RESET=1'b0.
- Sub-module sync_2ff: two-flop synchronizer with async active-low reset and parameter RST_VAL. Instantiated twice: Q (RST_VAL=0) and Qbar (RST_VAL=1).

Test Plan:
All scenarios use PULSE_CYCLES=4, GAP_CYCLES=2, with the NOR latch behavioural cell connected to S/R/Q/Qbar.

1. Hold rst_n=0 for 3 cycles, then release. S=R=0, cmd_ready=1, done=fault=0, invalid=0 throughout.
2. Set command: cmd_valid=1, cmd_set=1 accepted at edge 10.
   - S=1 cycles 11-14, R=0 throughout.
   - done=1, fault=0 at cycle 17; state_q=1; cmd_ready=1 at cycle 18.
3. Reset command immediately after scenario 2. R pulses 4 cycles, done without fault, state_q=0.
4. Fault injection: bench forces Q=0, Qbar=1 during a set command. done=1 and fault=1 in the CHECK cycle. Force Q=Qbar=0 and check that invalid=1 within 3 cycles.
5. Back-to-back: cmd_valid held high with alternating cmd_set.
   - Second accept occurs only in the IDLE cycle after CHECK.
   - Assertion that !(S&&R) holds every cycle.
   - Commands presented while busy are not captured.
6. Reset mid-pulse: rst_n=0 in the 2nd cycle of S high.
   - S falls without waiting for a clock edge.
   - No done/fault appears.
   - cmd_ready=1 on the first cycle after release.
